// File: rtl/fft_2d_frame_loader_if.sv
// rtl/fft_2d_frame_loader_if.sv - sample stream in, whole-frame handoff out, for the 2-D FFT frame loader
interface fft_2d_frame_loader_if #(
    parameter int DW = 16
) ();
    logic signed [DW-1:0]    in_r;
    logic signed [DW-1:0]    in_i;
    logic                    in_sof;
    logic                    in_valid;
    logic                    in_ready;
    logic        [16*DW-1:0] frame_r;
    logic        [16*DW-1:0] frame_i;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    err_sync;
    logic        [7:0]       frame_cnt;

    modport master (
        output in_r, in_i, in_sof, in_valid, frame_ready,
        input  in_ready, frame_r, frame_i, frame_valid, err_sync, frame_cnt
    );

    modport slave (
        input  in_r, in_i, in_sof, in_valid, frame_ready,
        output in_ready, frame_r, frame_i, frame_valid, err_sync, frame_cnt
    );
endinterface

// File: rtl/fft_2d_frame_loader.sv
// rtl/fft_2d_frame_loader.sv - gathers 16 serial complex samples row-major into a 4x4 frame for the 2-D FFT
module fft_2d_frame_loader #(
    parameter int DW = 16,
    parameter int N  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_2d_frame_loader_if.slave  bus
);
    localparam int NS = N * N;
    localparam int IW = $clog2(NS);

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NS*DW-1:0]    fr_q, fr_d;
    logic [NS*DW-1:0]    fi_q, fi_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                accept;

    assign accept = bus.in_valid && (state_q == FILL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            fr_q    <= '0;
            fi_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fr_q    <= fr_d;
            fi_q    <= fi_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fr_d    = fr_q;
        fi_d    = fi_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (bus.in_sof) begin
                        // sof always restarts the frame; mid-frame it also flags lost sync
                        fr_d[DW-1:0] = bus.in_r;
                        fi_d[DW-1:0] = bus.in_i;
                        idx_d        = IW'(1);
                        err_d        = (idx_q != '0);
                    end else if (idx_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        fr_d[DW*idx_q +: DW] = bus.in_r;
                        fi_d[DW*idx_q +: DW] = bus.in_i;
                        if (idx_q == IW'(NS-1)) begin
                            state_d = HOLD;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.in_ready    = (state_q == FILL);
    assign bus.frame_valid = (state_q == HOLD);
    assign bus.frame_r     = fr_q;
    assign bus.frame_i     = fi_q;
    assign bus.err_sync    = err_q;
    assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_fft_2d_frame_loader.sv
// tb/tb_fft_2d_frame_loader.sv - directed self-checking bench for fft_2d_frame_loader
module tb_fft_2d_frame_loader;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_2d_frame_loader_if #(.DW(16)) bus ();

    fft_2d_frame_loader #(.DW(16), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] fval(input int k);
        return 16'(16'h0200 + 16'h0100 * (k / 4 + k % 4));
    endfunction

    function automatic logic [15:0] el(input logic [255:0] v, input int k);
        return v[16*k +: 16];
    endfunction

    task automatic send(input logic [15:0] r, input logic [15:0] i, input logic sof);
        int n = 0;
        bus.in_r     = r;
        bus.in_i     = i;
        bus.in_sof   = sof;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_frame();
        bus.frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.frame_ready = 1'b0;
    endtask

    task automatic send_std_frame(input logic neg);
        for (int k = 0; k < 16; k++)
            send(fval(k), neg ? 16'(-fval(k)) : fval(k), k == 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0 || bus.err_sync !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready/valid/err=%b%b%b required 100", bus.in_ready, bus.frame_valid, bus.err_sync);
        end
        checks++;
        if (bus.frame_cnt !== 8'd0 || bus.frame_r !== '0 || bus.frame_i !== '0) begin
            errors++;
            $display("FAIL reset_data cnt=%0d r_nonzero=%b i_nonzero=%b required 0/0/0", bus.frame_cnt, |bus.frame_r, |bus.frame_i);
        end
    endtask

    task automatic test_fill();
        int bad = 0;
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) bus.frame_ready = 1'b0;
            send(fval(k), fval(k), k == 0);
            if (k == 14) begin
                checks++;
                if (bus.frame_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_early_valid frame_valid=%b required 0", bus.frame_valid);
                end
            end
        end
        checks++;
        if (bus.frame_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_latency valid/ready=%b%b required 10", bus.frame_valid, bus.in_ready);
        end
        checks++;
        if (el(bus.frame_r, 0) !== 16'h0200 || el(bus.frame_r, 15) !== 16'h0800) begin
            errors++;
            $display("FAIL fill_corners r11=%h r44=%h required 0200 0800", el(bus.frame_r, 0), el(bus.frame_r, 15));
        end
        for (int k = 0; k < 16; k++)
            if (el(bus.frame_r, k) !== fval(k) || el(bus.frame_i, k) !== fval(k)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_contents bad_elements=%0d required 0", bad);
        end
        checks++;
        if (bus.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fill_ready_ignored frame_cnt=%0d required 0", bus.frame_cnt);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = 1'b1;
        bus.in_r     = 16'h0111;
        bus.in_i     = 16'h0111;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1) bad++;
            for (int k = 0; k < 16; k++)
                if (el(bus.frame_r, k) !== fval(k) || el(bus.frame_i, k) !== fval(k)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable bad=%0d required 0", bad);
        end
        release_frame();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.frame_cnt !== 8'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release valid=%b cnt=%0d ready=%b required 0 1 1", bus.frame_valid, bus.frame_cnt, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k < 16; k++) send(fval(k), fval(k), 1'b0);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1 || el(bus.frame_r, 0) !== 16'h0111 || el(bus.frame_r, 15) !== 16'h0800) begin
            errors++;
            $display("FAIL hold_no_loss valid=%b r11=%h r44=%h required 1 0111 0800", bus.frame_valid, el(bus.frame_r, 0), el(bus.frame_r, 15));
        end
        release_frame();
    endtask

    task automatic test_sof_resync();
        for (int k = 0; k < 7; k++) send(16'(16'h0100 + k), 16'h0000, k == 0);
        checks++;
        if (bus.err_sync !== 1'b0) begin
            errors++;
            $display("FAIL resync_quiet err_sync=%b required 0", bus.err_sync);
        end
        send(16'h0AAA, 16'hF555, 1'b1);
        checks++;
        if (bus.err_sync !== 1'b1) begin
            errors++;
            $display("FAIL resync_pulse err_sync=%b required 1", bus.err_sync);
        end
        for (int k = 1; k < 16; k++) begin
            send(fval(k), fval(k), 1'b0);
            if (k == 1) begin
                checks++;
                if (bus.err_sync !== 1'b0) begin
                    errors++;
                    $display("FAIL resync_one_cycle err_sync=%b required 0", bus.err_sync);
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.frame_valid !== 1'b1 || el(bus.frame_r, 0) !== 16'h0AAA || el(bus.frame_i, 0) !== 16'hF555 || el(bus.frame_r, 7) !== fval(7)) begin
            errors++;
            $display("FAIL resync_frame valid=%b r11=%h i11=%h r24=%h required 1 0aaa f555 %h", bus.frame_valid, el(bus.frame_r, 0), el(bus.frame_i, 0), el(bus.frame_r, 7), fval(7));
        end
        release_frame();
        checks++;
        if (bus.frame_cnt !== 8'd3) begin
            errors++;
            $display("FAIL resync_cnt frame_cnt=%0d required 3", bus.frame_cnt);
        end
    endtask

    task automatic test_no_sof();
        int bad = 0;
        send(16'h1234, 16'h1234, 1'b0);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.err_sync !== 1'b1) begin
            errors++;
            $display("FAIL nosof_pulse err_sync=%b required 1", bus.err_sync);
        end
        for (int k = 0; k < 16; k++) begin
            send(fval(k), 16'(-fval(k)), k == 0);
            if (k == 14 && bus.frame_valid !== 1'b0) bad++;
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 16; k++)
            if (el(bus.frame_r, k) !== fval(k) || el(bus.frame_i, k) !== 16'(-fval(k))) bad++;
        checks++;
        if (bad != 0 || bus.frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL nosof_frame bad=%0d valid=%b required 0 1", bad, bus.frame_valid);
        end
        release_frame();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 9; k++) send(fval(k), fval(k), k == 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.frame_valid !== 1'b0 || bus.err_sync !== 1'b0 ||
            bus.frame_cnt !== 8'd0 || bus.frame_r !== '0 || bus.frame_i !== '0) begin
            errors++;
            $display("FAIL midreset_outputs ready=%b valid=%b err=%b cnt=%0d required 1 0 0 0", bus.in_ready, bus.frame_valid, bus.err_sync, bus.frame_cnt);
        end
        send_std_frame(1'b0);
        checks++;
        if (bus.frame_valid !== 1'b1 || el(bus.frame_r, 0) !== 16'h0200 || el(bus.frame_r, 15) !== 16'h0800) begin
            errors++;
            $display("FAIL midreset_frame valid=%b r11=%h r44=%h required 1 0200 0800", bus.frame_valid, el(bus.frame_r, 0), el(bus.frame_r, 15));
        end
        release_frame();
        checks++;
        if (bus.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL midreset_cnt frame_cnt=%0d required 1", bus.frame_cnt);
        end
    endtask

    task automatic test_wrap();
        int bad = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 16; k++) begin
                if ((f + k) % 7 == 0) idle();
                send(16'(f * 32 + k), 16'(-(f * 32 + k)), k == 0);
            end
            bus.in_valid = 1'b0;
            if (bus.frame_valid !== 1'b1) bad++;
            for (int k = 0; k < 16; k++)
                if (el(bus.frame_r, k) !== 16'(f * 32 + k) || el(bus.frame_i, k) !== 16'(-(f * 32 + k))) bad++;
            release_frame();
            if (f == 254) begin
                checks++;
                if (bus.frame_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255 frame_cnt=%0d required 255", bus.frame_cnt);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wrap_contents bad=%0d required 0", bad);
        end
        checks++;
        if (bus.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero frame_cnt=%0d required 0", bus.frame_cnt);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.in_r        = '0;
        bus.in_i        = '0;
        bus.in_sof      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.frame_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_hold();
        test_sof_resync();
        test_no_sof();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_2d_frame_loader.md
FFT_2D_FRAME_LOADER -- requirements
Module: fft_2d_frame_loader

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed width of each real/imaginary sample component.
REQ-002 SHALL have parameter N, fixed 4, meaning frame rows and columns (16 complex samples per frame).
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_r, input, DW signed, real part of the serial input sample.
REQ-006 SHALL have port in_i, input, DW signed, imaginary part of the serial input sample.
REQ-007 SHALL have port in_sof, input, 1, start-of-frame marker qualifying the current sample.
REQ-008 SHALL have port in_valid, input, 1, input sample valid.
REQ-009 SHALL have port in_ready, output, 1, loader accepts a sample this cycle.
REQ-010 SHALL have port frame_r, output, 16*DW, real parts of the frame; element (row r, col c), 1-based, at bits [DW*(4*(r-1)+(c-1)) +: DW].
REQ-011 SHALL have port frame_i, output, 16*DW, imaginary parts, same packing as frame_r.
REQ-012 SHALL have port frame_valid, output, 1, complete frame presented to the 2-D FFT.
REQ-013 SHALL have port frame_ready, input, 1, downstream FFT consumes the frame.
REQ-014 SHALL have port err_sync, output, 1, one-cycle pulse on framing error.
REQ-015 SHALL have port frame_cnt, output, 8, count of frames handed off, modulo 256.

Function
REQ-016 SHALL accept a sample only when in_valid and in_ready are both 1 in the same cycle.
REQ-017 SHALL store accepted samples row-major: index k (0..15) maps to row k/4+1, col k%4+1.
REQ-018 SHALL implement states FILL and HOLD; in_ready = 1 in FILL, 0 in HOLD.
REQ-019 SHALL, in FILL, on acceptance of index 15, move to HOLD and assert frame_valid on the next cycle (one-cycle latency from last sample).
REQ-020 SHALL hold frame_r, frame_i and frame_valid stable throughout HOLD.
REQ-021 SHALL, in HOLD with frame_ready = 1, deassert frame_valid, increment frame_cnt (255 wraps to 0), reset the index to 0, and return to FILL on the next cycle.
REQ-022 SHALL ignore frame_ready while in FILL.
REQ-023 SHALL drop an accepted sample with in_sof = 0 at index 0, leave the index at 0, and pulse err_sync for one cycle.
REQ-024 SHALL, on an accepted sample with in_sof = 1 at index 1..15, discard the partial frame, store the sample as index 0, set the index to 1, and pulse err_sync for one cycle.
REQ-025 SHALL treat an accepted in_sof = 1 at index 0 as a normal start with no error.
REQ-026 SHALL store sample bits unmodified: no scaling, rounding or sign change.
REQ-027 SHALL leave frame bus content undefined for verification purposes while frame_valid = 0.

Reset
REQ-028 SHALL, while rst_n = 0 at a clk edge, set state FILL, index 0, frame_valid 0, err_sync 0, frame_cnt 0, and frame_r/frame_i all zero.
REQ-029 SHALL drive in_ready 1 on the first cycle after rst_n returns to 1.
REQ-030 SHALL, on reset mid-fill or during HOLD, discard the partial or held frame; the next frame requires in_sof.

Verification
REQ-031 SHALL pass this scenario: 16 back-to-back samples, sof on first, r = i = 0x0200 + 0x0100*(row+col-2) (0x0200..0x0800) -> frame_valid one cycle after the 16th; element (1,1) = 0x0200, (4,4) = 0x0800.
REQ-032 SHALL pass this scenario: frame_ready held 0 for 10 cycles in HOLD, in_valid held 1 -> in_ready 0, bus unchanged, no samples lost; frame_ready 1 -> frame_valid 0 next cycle, frame_cnt 1.
REQ-033 SHALL pass this scenario: 7 samples, then a sample with sof = 1 and value 0x0AAA -> err_sync pulses once; completed frame has element (1,1) = 0x0AAA.
REQ-034 SHALL pass this scenario: first sample with sof = 0 (value 0x1234) -> err_sync pulses, sample absent from frame, index stays 0.
REQ-035 SHALL pass this scenario: rst_n = 0 for one cycle after 9 samples -> all outputs at reset values; a full new frame completes normally.
REQ-036 SHALL pass this scenario: 256 frames streamed -> frame_cnt returns to 0; in_valid gaps inside a frame do not affect contents.
